// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: round constants, round count and the
// message-schedule sigma functions for both 32- and 64-bit word sizes.
package sha2_pkg;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [31:0] K32 [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] K64 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    function automatic int sha2_rounds(input int word_w);
        return (word_w == 64) ? 80 : 64;
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // 32-bit results come back zero-extended in the low half.
    function automatic logic [63:0] sha2_sig0(input int word_w, input logic [63:0] x);
        if (word_w == 64)
            return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
        return {32'd0, rotr32(x[31:0], 7) ^ rotr32(x[31:0], 18) ^ (x[31:0] >> 3)};
    endfunction

    function automatic logic [63:0] sha2_sig1(input int word_w, input logic [63:0] x);
        if (word_w == 64)
            return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
        return {32'd0, rotr32(x[31:0], 17) ^ rotr32(x[31:0], 19) ^ (x[31:0] >> 10)};
    endfunction

endpackage

// File: rtl/sha2_k_rom.sv
// Combinational round-constant lookup; indices past the round count read 0.
module sha2_k_rom
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [6:0]        idx,
    output logic [WORD_W-1:0] k
);

    generate
        if (WORD_W == 32) begin : g_k32
            // Bit 6 set means idx >= 64, past the last SHA-256 round.
            always_comb begin
                k = '0;
                if (!idx[6]) k = K32[idx[5:0]];
            end
        end else begin : g_k64
            // Only 80 of the 128 index codes are populated.
            always_comb begin
                k = '0;
                if (idx < 7'd80) k = K64[idx];
            end
        end
    endgenerate

endmodule

// File: rtl/sha2_sched_gen.sv
// Streams one (K[t], W[t], K[t]+W[t]) tuple per round for a 16-word block,
// expanding the message schedule on the fly in a 16-deep shift register.
module sha2_sched_gen
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_blk_valid,
    output logic                 o_blk_ready,
    input  logic [16*WORD_W-1:0] i_blk_data,
    input  logic                 i_abort,
    output logic                 o_rnd_valid,
    input  logic                 i_rnd_ready,
    output logic [6:0]           o_rnd_idx,
    output logic [WORD_W-1:0]    o_rnd_k,
    output logic [WORD_W-1:0]    o_rnd_w,
    output logic [WORD_W-1:0]    o_rnd_kw,
    output logic                 o_rnd_last
);

    localparam int ROUNDS = sha2_rounds(WORD_W);

    generate
        if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
            $error("sha2_sched_gen: WORD_W must be 32 or 64");
        end
    endgenerate

    state_t                    state, state_nx;
    // w_q[0] is the oldest word; [0:15] ordering lets M0 (MSBs) land in w_q[0].
    logic [0:15][WORD_W-1:0]   w_q;
    logic [WORD_W-1:0]         k_q, k_nx, w_new, s0, s1;
    logic [6:0]                t_q, k_idx;
    logic                      last_q, accept, advance, killed;

    assign accept  = (state == ST_IDLE) && i_blk_valid;
    assign killed  = (state == ST_RUN) && i_abort;
    assign advance = (state == ST_RUN) && i_rnd_ready && !i_abort;

    // On accept the ROM is looked up at 0, otherwise one round ahead.
    assign k_idx = accept ? 7'd0 : t_q + 7'd1;

    sha2_k_rom #(.WORD_W(WORD_W)) u_k_rom (
        .idx (k_idx),
        .k   (k_nx)
    );

    assign s0    = WORD_W'(sha2_sig0(WORD_W, 64'(w_q[1])));
    assign s1    = WORD_W'(sha2_sig1(WORD_W, 64'(w_q[14])));
    assign w_new = s1 + w_q[9] + s0 + w_q[0];

    // Next-state and handshake decode
    always_comb begin
        state_nx    = state;
        o_blk_ready = 1'b0;
        o_rnd_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                o_blk_ready = 1'b1;
                if (i_blk_valid) state_nx = ST_RUN;
            end
            ST_RUN: begin
                o_rnd_valid = 1'b1;
                if (i_abort)                   state_nx = ST_IDLE;
                else if (i_rnd_ready && last_q) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // Schedule shift register, round counter and constant register; abort wins over advance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_q    <= '0;
            k_q    <= '0;
            t_q    <= '0;
            last_q <= 1'b0;
        end else if (accept) begin
            w_q    <= i_blk_data;
            k_q    <= k_nx;
            t_q    <= '0;
            last_q <= (ROUNDS == 1);
        end else if (killed) begin
            t_q    <= '0;
            last_q <= 1'b0;
        end else if (advance) begin
            w_q    <= {w_q[1:15], w_new};
            k_q    <= k_nx;
            t_q    <= t_q + 7'd1;
            last_q <= (t_q + 7'd1 == 7'(ROUNDS - 1));
        end
    end

    assign o_rnd_idx  = t_q;
    assign o_rnd_k    = k_q;
    assign o_rnd_w    = w_q[0];
    assign o_rnd_kw   = k_q + w_q[0];
    assign o_rnd_last = last_q;

endmodule

// File: doc/sha2_sched_gen.md
# sha2_sched_gen

Parametrised SHA-2 round-input generator that streams one (K[t], W[t], K[t]+W[t]) tuple per round for a 16-word message block. It replaces the fixed 32-bit round-constant ROM with one source that holds the constants and expands the message schedule on the fly. It covers SHA-224/256 (32-bit, 64 rounds) and SHA-384/512 (64-bit, 80 rounds). It sits between the block padder and the compression round datapath, with valid/ready handshakes on both sides.

## Interface
- WORD_W, 32, word width; legal values are 32 (64 rounds) and 64 (80 rounds). Any other value is a elaboration error.
- ROUNDS, localparam, 64 when WORD_W=32, 80 when WORD_W=64.
- Reset is asynchronous and active-low. One clock.
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_blk_valid  in  1  a block is presented on i_blk_data.
- o_blk_ready  out  1  the block is accepted when i_blk_valid and o_blk_ready are both high.
- i_blk_data  in  16*WORD_W  message words M0..M15; M0 occupies the MSBs.
- i_abort  in  1  synchronous abort of the block in flight.
- o_rnd_valid  out  1  a round tuple is presented.
- i_rnd_ready  in  1  the consumer accepts the tuple.
- o_rnd_idx  out  7  round index t.
- o_rnd_k  out  WORD_W  K[t].
- o_rnd_w  out  WORD_W  W[t].
- o_rnd_kw  out  WORD_W  (K[t]+W[t]) mod 2^WORD_W.
- o_rnd_last  out  1  high when t = ROUNDS-1.

## Operation
- States:
  - IDLE: o_blk_ready=1, o_rnd_valid=0.
  - RUN: o_blk_ready=0, o_rnd_valid=1.
- IDLE→RUN on block accept:
  - Shift register w[0..15] loads M0..M15.
  - k_q loads ROM[0].
  - t loads 0.
- An advance is o_rnd_valid & i_rnd_ready in RUN. On advance:
  - w[i] takes w[i+1].
  - w[15] takes σ1(w[14]) + w[9] + σ0(w[1]) + w[0].
  - k_q takes ROM[t+1].
  - t increments.
- Output mapping: o_rnd_w = w[0], o_rnd_k = k_q, o_rnd_kw = k_q + w[0]. All sums are truncated mod 2^WORD_W.
- The same recurrence is used for every t. There is no special case for t<16.
- Sigma functions, WORD_W=32:
  - σ0 = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1 = ROTR17 ^ ROTR19 ^ SHR10.
- Sigma functions, WORD_W=64:
  - σ0 = ROTR1 ^ ROTR8 ^ SHR7.
  - σ1 = ROTR19 ^ ROTR61 ^ SHR6.
- An advance at t = ROUNDS-1 moves RUN→IDLE.
- Stall (o_rnd_valid=1, i_rnd_ready=0): all o_rnd_* outputs hold stable.
- i_abort in RUN: next state is IDLE and t clears. Abort has priority over a simultaneous advance. i_abort in IDLE is ignored.
- In IDLE, o_rnd_k/w/kw/idx hold their last values and are don't-care. The verifier checks them only while o_rnd_valid=1.
- Reset values: state IDLE, o_blk_ready=1, o_rnd_valid=0, o_rnd_idx=0, o_rnd_last=0. The w shift register and k_q clear to 0, so o_rnd_k, o_rnd_w and o_rnd_kw are 0.
- Asserting i_rst_n low mid-block discards the block immediately. There is no output activity until the next accept.

## Timing
- Block accepted at edge N → first tuple (t=0) valid after edge N.
- With i_rnd_ready held high, one tuple is produced per cycle. Round t is presented in cycle N+1+t.
- Throughput is ROUNDS+1 cycles per block: one IDLE accept cycle, then ROUNDS run cycles.
- o_blk_ready is a combinational decode of state. All other outputs come from registers, or from a single adder on registers (o_rnd_kw).
- Critical path: σ plus a 4-operand add in the schedule update, and one 2-operand add for kw. There is no pipelining within a round.

## Structure
- The shared package sha2_pkg holds:
  - the K tables K32[0:63] and K64[0:79];
  - the function sha2_rounds(WORD_W);
  - the sigma functions, parametrised by WORD_W.
- K32[i] equals the upper 32 bits of K64[i] for i<64.
- One sub-module, sha2_k_rom (parameter WORD_W, 7-bit index in, WORD_W out), is combinational. Indices ≥ ROUNDS return 0.
- FSM, counter, shift register and adders live in sha2_sched_gen.

## Test plan
- WORD_W=32, "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), i_rnd_ready=1:
  - t=0: k=0x428a2f98, w=0x61626380, kw=0xa3ec9318.
  - t=16: w=0x61626380.
  - t=17: w=0x000f0000.
  - t=63: k=0xc67178f2, last=1.
  - Then IDLE with o_blk_ready=1.
- Backpressure: drop i_rnd_ready for 5 cycles at t=20 → idx, k, w and kw are frozen throughout. Total block time is 64+1+5 cycles.
- Back-to-back blocks, i_blk_valid held high → second accept in the cycle after the t=63 advance; second block t=0 starts one cycle later.
- Abort at t=30 together with i_rnd_ready=1 → the next cycle is IDLE with o_rnd_valid=0. A new block restarts at t=0 with correct values.
- Reset mid-block at t=40 → all outputs reach their reset values immediately. The next block runs from t=0 and matches the golden model.
- WORD_W=64, "abc" SHA-512 block (M0=0x6162638000000000, M15=0x18):
  - t=0: k=0x428a2f98d728ae22.
  - t=79: k=0x6c44198c4a475817, last=1.
  - All 80 W values match the reference model.
